// File: rtl/matrix_pkg.sv
// Shared definitions for the LED matrix frame sequencer: FSM states, default geometry
// and the chain-to-pixel snake mapping.
package matrix_pkg;

  localparam int NUM_LEDS_DEF   = 64;
  localparam int COLS_DEF       = 8;
  localparam int START_BITS_DEF = 32;
  localparam int END_BITS_DEF   = 64;
  localparam int WORD_BITS      = 32;
  localparam int NUM_SRC        = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_FETCH,
    ST_SHIFT,
    ST_END,
    ST_DONE
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Chain position n to logical pixel row*cols+col; even rows are wired right to left.
  function automatic int snake_map(input int n, input int cols);
    int row;
    int col;
    row = n / cols;
    col = n % cols;
    if ((row % 2) == 0) begin
      col = cols - 1 - col;
    end
    return row * cols + col;
  endfunction

endpackage

// File: rtl/matrix_bit_shifter.sv
// Serialises a loaded word as 2-cycle slots (clock low then high), MSB first.
// done pulses during the high phase of the final slot so the next load can follow seamlessly.
module matrix_bit_shifter
  import matrix_pkg::*;
#(
  parameter int CNT_W = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WORD_BITS-1:0] load_word,
  input  logic [CNT_W-1:0]     load_len,
  output logic                 led_clk,
  output logic                 led_data,
  output logic                 done
);

  logic                 active_q, active_d;
  logic                 phase_q, phase_d;
  logic [WORD_BITS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      phase_q  <= 1'b0;
      shreg_q  <= '0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      phase_q  <= phase_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    active_d = active_q;
    phase_d  = phase_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    done     = 1'b0;
    if (active_q) begin
      if (!phase_q) begin
        phase_d = 1'b1;
      end else if (cnt_q == CNT_W'(1)) begin
        active_d = 1'b0;
        phase_d  = 1'b0;
        done     = 1'b1;
      end else begin
        phase_d = 1'b0;
        cnt_d   = cnt_q - CNT_W'(1);
        shreg_d = {shreg_q[WORD_BITS-2:0], 1'b0};
      end
    end
    // Zero runs longer than a word just keep shifting zeros out of the register.
    if (load) begin
      active_d = 1'b1;
      phase_d  = 1'b0;
      shreg_d  = load_word;
      cnt_d    = load_len;
    end
  end

  assign led_clk  = active_q & phase_q;
  assign led_data = active_q & shreg_q[WORD_BITS-1];

endmodule

// File: rtl/matrix_frame_sequencer.sv
// Shares the APA102-style matrix link between two frame sources: round-robin frame grant,
// start frame, one fetched pixel per LED in snake order, end frame.
module matrix_frame_sequencer
  import matrix_pkg::*;
#(
  parameter  int NUM_LEDS   = NUM_LEDS_DEF,
  parameter  int COLS       = COLS_DEF,
  parameter  int START_BITS = START_BITS_DEF,
  parameter  int END_BITS   = END_BITS_DEF,
  localparam int AW         = $clog2(NUM_LEDS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_SRC-1:0]   frame_req,
  output logic [NUM_SRC-1:0]   frame_gnt,
  output logic                 frame_done,
  input  logic [WORD_BITS-1:0] fg_colour,
  input  logic [WORD_BITS-1:0] bg_colour,
  output logic                 px_req,
  output logic [AW-1:0]        px_addr,
  input  logic [NUM_SRC-1:0]   px_valid,
  input  logic [NUM_SRC-1:0]   px_bit,
  output logic                 led_clk,
  output logic                 led_data,
  output logic                 busy
);

  localparam int            CNT_W    = $clog2(max3(START_BITS, END_BITS, WORD_BITS) + 1);
  localparam logic [AW-1:0] LAST_LED = AW'(NUM_LEDS - 1);

  state_t               state_q, state_d;
  logic [NUM_SRC-1:0]   gnt_q, gnt_d;
  logic                 last_q, last_d;
  logic [WORD_BITS-1:0] fg_q, fg_d;
  logic [WORD_BITS-1:0] bg_q, bg_d;
  logic [AW-1:0]        n_q, n_d;

  logic                 sh_load;
  logic [WORD_BITS-1:0] sh_word;
  logic [CNT_W-1:0]     sh_len;
  logic                 sh_done;

  logic [NUM_SRC-1:0]   valid_masked;
  logic [NUM_SRC-1:0]   bit_masked;
  logic                 px_valid_g;
  logic                 px_bit_g;
  logic                 pick;

  // Only the granted source's pixel handshake reaches the FSM.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign valid_masked[gi] = px_valid[gi] & gnt_q[gi];
    assign bit_masked[gi]   = px_bit[gi] & gnt_q[gi];
  end

  assign px_valid_g = |valid_masked;
  assign px_bit_g   = |bit_masked;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= 1'b1;
      fg_q    <= '0;
      bg_q    <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      fg_q    <= fg_d;
      bg_q    <= bg_d;
      n_q     <= n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    fg_d    = fg_q;
    bg_d    = bg_q;
    n_d     = n_q;
    sh_load = 1'b0;
    sh_word = '0;
    sh_len  = '0;
    // last_q holds the index of the source that finished the previous frame.
    pick    = (frame_req == 2'b11) ? ~last_q : frame_req[1];

    unique case (state_q)
      ST_IDLE: begin
        if (|frame_req) begin
          gnt_d   = pick ? 2'b10 : 2'b01;
          fg_d    = fg_colour;
          bg_d    = bg_colour;
          n_d     = '0;
          sh_load = 1'b1;
          sh_len  = CNT_W'(START_BITS);
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (sh_done) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (px_valid_g) begin
          sh_load = 1'b1;
          sh_word = px_bit_g ? fg_q : bg_q;
          sh_len  = CNT_W'(WORD_BITS);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sh_done) begin
          if (n_q == LAST_LED) begin
            sh_load = 1'b1;
            sh_len  = CNT_W'(END_BITS);
            state_d = ST_END;
          end else begin
            n_d     = n_q + AW'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_END: begin
        if (sh_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        gnt_d   = '0;
        last_d  = gnt_q[1];
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  matrix_bit_shifter #(
    .CNT_W(CNT_W)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (sh_load),
    .load_word(sh_word),
    .load_len (sh_len),
    .led_clk  (led_clk),
    .led_data (led_data),
    .done     (sh_done)
  );

  assign frame_gnt  = gnt_q;
  assign frame_done = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign px_req     = (state_q == ST_FETCH);
  assign px_addr    = px_req ? AW'(snake_map(int'(n_q), COLS)) : '0;

endmodule

// File: tb/tb_matrix_frame_sequencer.sv
// Directed frames for matrix_frame_sequencer; stimulus queues expected grants, addresses
// and LED words, and a negedge monitor deserialises the link and checks against them.
`timescale 1ns/1ps
module tb_matrix_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  frame_req;
  logic [1:0]  frame_gnt;
  logic        frame_done;
  logic [31:0] fg_colour;
  logic [31:0] bg_colour;
  logic        px_req;
  logic [5:0]  px_addr;
  logic [1:0]  px_valid;
  logic [1:0]  px_bit;
  logic        led_clk;
  logic        led_data;
  logic        busy;

  always #5 clk = ~clk;

  matrix_frame_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .frame_req (frame_req),
    .frame_gnt (frame_gnt),
    .frame_done(frame_done),
    .fg_colour (fg_colour),
    .bg_colour (bg_colour),
    .px_req    (px_req),
    .px_addr   (px_addr),
    .px_valid  (px_valid),
    .px_bit    (px_bit),
    .led_clk   (led_clk),
    .led_data  (led_data),
    .busy      (busy)
  );

  localparam logic [5:0] DELAY_ADDR = 6'h0A;
  localparam int         DELAY      = 5;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_w_q[$];
  logic [5:0]  exp_a_q[$];
  logic [1:0]  exp_g_q[$];
  bit          mon_en   = 1'b1;
  bit          del_en   = 1'b0;
  bit          gap_chk  = 1'b0;
  int          pix_mode = 0;
  int          exp_len  = 0;

  int          cyc      = 0;
  int          done_cnt = 0;
  int          bad_gnt  = 0;
  int          bits     = 0;
  int          rise_cyc = 0;
  int          done_cyc = 0;
  logic [1:0]  rise_gnt = 2'b00;
  logic [1:0]  prev_gnt = 2'b00;
  logic        prev_req = 1'b0;
  logic [31:0] word     = 32'h0;

  int          wait_cnt  = 0;
  logic [5:0]  held_addr = 6'h0;
  logic        g_idx;
  logic        v_out;
  logic        b_out;

  function automatic logic [5:0] tb_addr(input int n);
    int row;
    int col;
    row = n / 8;
    col = n % 8;
    if ((row & 1) == 0) col = 7 - col;
    return 6'(row * 8 + col);
  endfunction

  function automatic logic pix(input int mode, input logic [5:0] a);
    case (mode)
      1:       return (a == 6'd0);
      2:       return a[0] ^ a[3];
      3:       return (a[5:3] == a[2:0]);
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic summary_and_finish();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic give_up(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", nm);
    summary_and_finish();
  endtask

  task automatic push_frame(input logic [1:0] g, input logic [31:0] fg, input logic [31:0] bg,
                            input int mode);
    logic [5:0] a;
    exp_g_q.push_back(g);
    exp_w_q.push_back(32'h0);
    for (int n = 0; n < 64; n++) begin
      a = tb_addr(n);
      exp_a_q.push_back(a);
      exp_w_q.push_back(pix(mode, a) ? fg : bg);
    end
    exp_w_q.push_back(32'h0);
    exp_w_q.push_back(32'h0);
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (frame_done) return;
    end
    give_up(nm);
  endtask

  task automatic wait_gnt(input string nm);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_gnt != 2'b00) return;
    end
    give_up(nm);
  endtask

  task automatic wait_fetch(input logic [5:0] a, input string nm);
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (px_req && px_addr == a) return;
    end
    give_up(nm);
  endtask

  task automatic wait_req_low(input string nm);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!px_req) return;
    end
    give_up(nm);
  endtask

  task automatic run_frame(input logic [1:0] req, input logic [31:0] fg, input logic [31:0] bg,
                           input int mode, input int len);
    exp_len  = len;
    pix_mode = mode;
    push_frame(req, fg, bg, mode);
    frame_req = req;
    fg_colour = fg;
    bg_colour = bg;
    wait_done("frame_done_timeout");
    frame_req = 2'b00;
  endtask

  // Monitor: grants, pixel addresses, deserialised LED words, frame timing.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        bits     = 0;
        prev_gnt = 2'b00;
        prev_req = 1'b0;
      end else begin
        if (frame_gnt == 2'b11) bad_gnt++;
        if (prev_gnt == 2'b00 && frame_gnt != 2'b00) begin
          if (exp_g_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_unexpected: got %b expected none", frame_gnt);
          end else begin
            chk("grant", 64'(frame_gnt), 64'(exp_g_q.pop_front()));
          end
          if (gap_chk) chk("frame_gap", 64'(cyc - done_cyc), 64'(2));
          rise_cyc = cyc;
          rise_gnt = frame_gnt;
        end
        if (led_clk) begin
          word = {word[30:0], led_data};
          bits++;
          if (bits == 32) begin
            bits = 0;
            if (mon_en) begin
              if (exp_w_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL led_word_unexpected: got %h expected none", word);
              end else begin
                chk("led_word", 64'(word), 64'(exp_w_q.pop_front()));
              end
            end
          end
        end
        if (mon_en && px_req && !prev_req) begin
          if (exp_a_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL px_addr_unexpected: got %h expected none", px_addr);
          end else begin
            chk("px_addr", 64'(px_addr), 64'(exp_a_q.pop_front()));
          end
        end
        if (frame_done) begin
          chk("gnt_held", 64'(frame_gnt), 64'(rise_gnt));
          chk("word_align", 64'(bits), 64'(0));
          if (exp_len > 0) chk("frame_len", 64'(cyc - rise_cyc), 64'(exp_len));
          done_cyc = cyc;
          done_cnt++;
        end
        prev_gnt = frame_gnt;
        prev_req = px_req;
      end
    end
  end

  // Pixel sources: granted source answers with the test pattern, the other one is
  // always valid with the inverted value so honouring it would corrupt the words.
  initial begin
    px_valid = 2'b00;
    px_bit   = 2'b00;
    forever begin
      @(negedge clk);
      g_idx = frame_gnt[1];
      v_out = 1'b0;
      if (px_req) begin
        if (del_en && px_addr == DELAY_ADDR && wait_cnt < DELAY) begin
          if (wait_cnt > 0) begin
            chk("wait_led_clk", 64'(led_clk), 64'(0));
            chk("wait_led_data", 64'(led_data), 64'(0));
            chk("wait_addr_stable", 64'(px_addr), 64'(held_addr));
          end else begin
            held_addr = px_addr;
          end
          wait_cnt++;
        end else begin
          v_out = 1'b1;
        end
      end else begin
        wait_cnt = 0;
      end
      b_out            = pix(pix_mode, px_addr);
      px_valid[g_idx]  = v_out;
      px_bit[g_idx]    = b_out;
      px_valid[!g_idx] = 1'b1;
      px_bit[!g_idx]   = !b_out;
    end
  end

  initial begin
    reset     = 1'b1;
    frame_req = 2'b00;
    fg_colour = 32'h0;
    bg_colour = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 64'(frame_gnt), 64'(0));
    chk("rst_done", 64'(frame_done), 64'(0));
    chk("rst_px_req", 64'(px_req), 64'(0));
    chk("rst_px_addr", 64'(px_addr), 64'(0));
    chk("rst_led_clk", 64'(led_clk), 64'(0));
    chk("rst_led_data", 64'(led_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'(0));

    // T1: all background, single source 0
    run_frame(2'b01, 32'hF0000F00, 32'hF0070000, 0, 4352);
    // T2: only pixel 0 lit -> 8th LED word is foreground
    run_frame(2'b01, 32'hF0000F00, 32'hF0070000, 1, 4352);

    // T6: source 1; request and colours change after grant
    exp_len  = 4352;
    pix_mode = 2;
    push_frame(2'b10, 32'hE1234567, 32'hE0ABCDEF, 2);
    frame_req = 2'b10;
    fg_colour = 32'hE1234567;
    bg_colour = 32'hE0ABCDEF;
    wait_gnt("t6_gnt_timeout");
    frame_req = 2'b00;
    fg_colour = 32'hFFFFFFFF;
    bg_colour = 32'h00000000;
    wait_done("t6_done_timeout");

    // T3: both sources request continuously
    exp_len  = 4352;
    pix_mode = 3;
    push_frame(2'b01, 32'hE0FF0000, 32'hE000FF00, 3);
    push_frame(2'b10, 32'hE0FF0000, 32'hE000FF00, 3);
    push_frame(2'b01, 32'hE0FF0000, 32'hE000FF00, 3);
    fg_colour = 32'hE0FF0000;
    bg_colour = 32'hE000FF00;
    frame_req = 2'b11;
    wait_done("t3_done0_timeout");
    gap_chk = 1'b1;
    wait_done("t3_done1_timeout");
    wait_done("t3_done2_timeout");
    frame_req = 2'b00;
    gap_chk   = 1'b0;

    // T4: slow pixel answer at n=10
    del_en = 1'b1;
    run_frame(2'b01, 32'h00FF00FF, 32'h80000001, 3, 4357);
    del_en = 1'b0;

    // T5: reset during SHIFT of n=20, then a clean frame with round-robin reset
    mon_en   = 1'b0;
    exp_len  = 0;
    pix_mode = 2;
    exp_g_q.push_back(2'b01);
    fg_colour = 32'hAAAAAAAA;
    bg_colour = 32'h55555555;
    frame_req = 2'b01;
    wait_fetch(6'h13, "t5_fetch_timeout");
    wait_req_low("t5_shift_timeout");
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_led_clk", 64'(led_clk), 64'(0));
    chk("abort_led_data", 64'(led_data), 64'(0));
    chk("abort_gnt", 64'(frame_gnt), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_px_req", 64'(px_req), 64'(0));
    @(negedge clk);
    reset    = 1'b0;
    mon_en   = 1'b1;
    exp_len  = 4352;
    push_frame(2'b01, 32'hC0C0C0C0, 32'h0F0F0F0F, 2);
    fg_colour = 32'hC0C0C0C0;
    bg_colour = 32'h0F0F0F0F;
    frame_req = 2'b11;
    wait_done("t5_done_timeout");
    frame_req = 2'b00;
    repeat (4) @(negedge clk);

    chk("done_count", 64'(done_cnt), 64'(8));
    chk("both_gnt_cycles", 64'(bad_gnt), 64'(0));
    chk("words_left", 64'(exp_w_q.size()), 64'(0));
    chk("addrs_left", 64'(exp_a_q.size()), 64'(0));
    chk("grants_left", 64'(exp_g_q.size()), 64'(0));
    chk("final_busy", 64'(busy), 64'(0));
    summary_and_finish();
  end

endmodule
